uart_line_receiver: RTL

//  Receive-side companion to the button-triggered UART sender. Consumes the byte strobes
//  (rx_data/rx_ready) of the uart_basic 115200/8N1 core and assembles them into

---
 rtl/uart_line_receiver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_line_receiver.sv
// Assembles uart_basic byte strobes into terminator-delimited lines held for a ready/ack consumer.
// Optional echo of stored bytes to the transmitter when UART_LINE_RX_ECHO_EN is defined.
module uart_line_receiver #(
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  TERM_CHAR   = 8'h0D,
    parameter logic [7:0]  IGNORE_CHAR = 8'h0A,
    parameter int          LEN_W       = 5,
    parameter int          ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              frame_ready,
    output logic [LEN_W-1:0]  frame_len,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              overflow,
    output logic              overrun,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);

    typedef enum logic [2:0] {
        S_COLLECT = 3'b001,
        S_DISCARD = 3'b010,
        S_READY   = 3'b100
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_count;
    logic               r_frame_ready;
    logic [LEN_W-1:0]   r_frame_len;
    logic               r_overflow;
    logic               r_overrun;
    logic [7:0]         r_rd_data;
    logic [7:0]         r_buf [MAX_LEN];

    logic               w_is_term;
    logic               w_byte;
    logic               w_full;
    logic               w_ack;
    logic               w_store;
    logic [ADDR_W-1:0]  w_wr_addr;

    assign w_is_term = (rx_data == TERM_CHAR);
    assign w_byte    = rx_ready && (rx_data != IGNORE_CHAR);
    assign w_full    = (r_count == LEN_W'(MAX_LEN));
    assign w_ack     = (r_state == S_READY) && frame_ack;
    // A byte landing in the ack cycle starts the next line at index 0.
    assign w_store   = w_byte && !w_is_term && (((r_state == S_COLLECT) && !w_full) || w_ack);
    assign w_wr_addr = w_ack ? '0 : r_count[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_COLLECT;
            r_count       <= '0;
            r_frame_ready <= 1'b0;
            r_frame_len   <= '0;
            r_overflow    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            r_overrun  <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_byte) begin
                        if (w_is_term) begin
                            if (r_count != '0) begin
                                r_frame_len   <= r_count;
                                r_frame_ready <= 1'b1;
                                r_state       <= S_READY;
                            end
                        end else if (!w_full) begin
                            r_count <= r_count + LEN_W'(1);
                        end else begin
                            r_overflow <= 1'b1;
                            r_count    <= '0;
                            r_state    <= S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_byte && w_is_term) r_state <= S_COLLECT;
                end
                S_READY: begin
                    if (frame_ack) begin
                        r_frame_ready <= 1'b0;
                        r_count       <= w_store ? LEN_W'(1) : '0;
                        r_state       <= S_COLLECT;
                    end else if (w_byte) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_COLLECT;
                    r_count       <= '0;
                    r_frame_ready <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the line buffer has no reset; its contents are only meaningful below frame_len.
    always_ff @(posedge clk) begin
        if (w_store) r_buf[w_wr_addr] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rd_data <= 8'h00;
        else          r_rd_data <= r_buf[rd_addr];
    end

    assign frame_ready = r_frame_ready;
    assign frame_len   = r_frame_len;
    assign overflow    = r_overflow;
    assign overrun     = r_overrun;
    assign rd_data     = r_rd_data;

`ifdef UART_LINE_RX_ECHO_EN
    logic       r_echo_pend;
    logic [7:0] r_echo_byte;
    logic       r_tx_start;
    logic [7:0] r_tx_data;

    // A store in the launch cycle re-arms pending with the newer byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_pend <= 1'b0;
            r_echo_byte <= 8'h00;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            if (r_echo_pend && !tx_busy && !r_tx_start) begin
                r_tx_start  <= 1'b1;
                r_tx_data   <= r_echo_byte;
                r_echo_pend <= 1'b0;
            end
            if (w_store) begin
                r_echo_byte <= rx_data;
                r_echo_pend <= 1'b1;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
`else
    logic w_unused_tx_busy;
    assign w_unused_tx_busy = tx_busy;
    assign tx_start = 1'b0;
    assign tx_data  = 8'h00;
`endif

endmodule
